// File: rtl/matrix_scan_ctrl.sv
// Scan sequencer for the 8x8 row/column decoder: walks cells 0..63 with a programmable
// dwell, double-buffers the frame, and emits a pixel-enable aligned to the decoder's
// registered output. Optional macro SCAN_BLANK_EN inserts one blank cycle after each cell.
module matrix_scan_ctrl #(
    parameter int unsigned DWELL = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] frame_in,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic        enable,
    output logic [5:0]  add,
    output logic        pix_on,
    output logic        frame_done,
    output logic        busy
);

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned FRAME_W  = 64;

`ifdef SCAN_BLANK_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1
    } state_t;
`endif

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [FRAME_W-1:0] active;
    logic [FRAME_W-1:0] pending;
    logic               pending_valid;

    logic last_dwell_c;
    logic last_cell_c;
    logic wrap_c;
    logic start_c;
    logic swap_c;
    logic accept_c;

    // Frame boundary, start and handshake decodes shared by the register block.
    always_comb begin
        last_dwell_c = (count == CNT_W'(DWELL - 1));
        last_cell_c  = (add == ADDR_W'(FRAME_W - 1));
`ifdef SCAN_BLANK_EN
        wrap_c       = (state == BLANK) && last_cell_c;
`else
        wrap_c       = (state == SCAN) && last_dwell_c && last_cell_c;
`endif
        start_c      = (state == IDLE) && enable;
        // Swap uses the registered pending_valid, so a frame accepted on this edge waits.
        swap_c       = pending_valid && (wrap_c || start_c);
        accept_c     = frame_valid && !pending_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            active        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            add           <= '0;
            pix_on        <= 1'b0;
            frame_done    <= 1'b0;
            busy          <= 1'b0;
            frame_ready   <= 1'b1;
        end else begin
            frame_done <= 1'b0;

            if (accept_c) begin
                pending       <= frame_in;
                pending_valid <= 1'b1;
            end else if (swap_c) begin
                pending_valid <= 1'b0;
            end
            frame_ready <= !(accept_c || (pending_valid && !swap_c));

            if (swap_c) begin
                active <= pending;
            end

            case (state)
                IDLE: begin
                    pix_on <= 1'b0;
                    if (enable) begin
                        state <= SCAN;
                        add   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end

                SCAN: begin
                    pix_on <= active[add];
                    if (last_dwell_c) begin
                        count <= '0;
`ifdef SCAN_BLANK_EN
                        state <= BLANK;
`else
                        add <= add + ADDR_W'(1);
                        if (last_cell_c) begin
                            frame_done <= 1'b1;
                            if (!enable) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
`endif
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end

`ifdef SCAN_BLANK_EN
                // One dark cycle between cells; the cell step and frame wrap happen on exit.
                BLANK: begin
                    pix_on <= 1'b0;
                    add    <= add + ADDR_W'(1);
                    count  <= '0;
                    if (last_cell_c) begin
                        frame_done <= 1'b1;
                        if (!enable) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= SCAN;
                        end
                    end else begin
                        state <= SCAN;
                    end
                end
`endif

                default: begin
                    state  <= IDLE;
                    pix_on <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Randomized bench for matrix_scan_ctrl: two instances (different DWELL) share stimulus
// and are compared every cycle against a frame-position reference model.
`timescale 1ns/1ps
module tb_matrix_scan_ctrl;

`ifdef SCAN_BLANK_EN
    localparam int unsigned EXTRA = 1;
    localparam int unsigned DW0   = 3;
`else
    localparam int unsigned EXTRA = 0;
    localparam int unsigned DW0   = 2;
`endif
    localparam int unsigned DW1 = 1;

    logic        clk;
    logic        rst;
    logic [63:0] frame_in;
    logic        frame_valid;
    logic        enable;

    logic        frame_ready [2];
    logic [5:0]  add         [2];
    logic        pix_on      [2];
    logic        frame_done  [2];
    logic        busy        [2];

    int n_tests;
    int n_fail;

    // Reference state: position t within the frame, running flag, buffers.
    int unsigned m_dw   [2];
    int unsigned m_t    [2];
    bit          m_run  [2];
    logic [63:0] m_act  [2];
    logic [63:0] m_pend [2];
    bit          m_pv   [2];
    bit          m_pix  [2];
    bit          m_done [2];

    matrix_scan_ctrl #(.DWELL(DW0)) u_dut0 (
        .clk         (clk),
        .rst         (rst),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready[0]),
        .enable      (enable),
        .add         (add[0]),
        .pix_on      (pix_on[0]),
        .frame_done  (frame_done[0]),
        .busy        (busy[0])
    );

    matrix_scan_ctrl #(.DWELL(DW1)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready[1]),
        .enable      (enable),
        .add         (add[1]),
        .pix_on      (pix_on[1]),
        .frame_done  (frame_done[1]),
        .busy        (busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Advance the reference one clock edge using the inputs present at that edge.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int unsigned per;
            int unsigned len;
            int unsigned idx;
            bit acc;
            bit swap;
            if (rst) begin
                m_t[i]    = 0;
                m_run[i]  = 0;
                m_act[i]  = '0;
                m_pend[i] = '0;
                m_pv[i]   = 0;
                m_pix[i]  = 0;
                m_done[i] = 0;
                continue;
            end
            per  = m_dw[i] + EXTRA;
            len  = 64 * per;
            acc  = frame_valid && !m_pv[i];
            swap = 0;
            m_pix[i]  = 0;
            m_done[i] = 0;
            if (!m_run[i]) begin
                if (enable) begin
                    m_run[i] = 1;
                    m_t[i]   = 0;
                    swap     = m_pv[i];
                end
            end else begin
                idx = m_t[i] / per;
                m_pix[i] = ((m_t[i] % per) < m_dw[i]) && m_act[i][idx];
                if (m_t[i] == len - 1) begin
                    m_done[i] = 1;
                    swap      = m_pv[i];
                    m_t[i]    = 0;
                    m_run[i]  = enable;
                end else begin
                    m_t[i] = m_t[i] + 1;
                end
            end
            if (swap) m_act[i] = m_pend[i];
            m_pv[i] = acc ? 1'b1 : (m_pv[i] && !swap);
            if (acc) m_pend[i] = frame_in;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < 2; i++) begin
            int unsigned per;
            per = m_dw[i] + EXTRA;
            check_eq($sformatf("add[%0d]", i),         64'(add[i]),         64'(m_t[i] / per));
            check_eq($sformatf("pix_on[%0d]", i),      64'(pix_on[i]),      64'(m_pix[i]));
            check_eq($sformatf("frame_done[%0d]", i),  64'(frame_done[i]),  64'(m_done[i]));
            check_eq($sformatf("busy[%0d]", i),        64'(busy[i]),        64'(m_run[i]));
            check_eq($sformatf("frame_ready[%0d]", i), 64'(frame_ready[i]), 64'(!m_pv[i]));
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        m_dw[0]     = DW0;
        m_dw[1]     = DW1;
        rst         = 1'b1;
        enable      = 1'b0;
        frame_valid = 1'b0;
        frame_in    = '0;
        run(2);
        rst = 1'b0;
        run(10);

        // Single lit cell 0, then continuous scanning.
        frame_in    = 64'h1;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        enable      = 1'b1;
        run(64 * (DW0 + EXTRA) + 20);

        // A queued, then B mid-frame, then C offered while the pending buffer is full.
        frame_in    = 64'h8000_0000_0000_0001;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        run(100);
        frame_in    = 64'h0000_0000_0000_00FF;
        frame_valid = 1'b1;
        tick();
        frame_in    = 64'hDEAD_BEEF_0BAD_F00D;
        run(20);
        frame_valid = 1'b0;
        run(2 * 64 * (DW0 + EXTRA) + 10);

        // Enable drops mid-frame: each instance finishes its frame and idles.
        enable = 1'b0;
        run(64 * (DW0 + EXTRA) + 20);

        // Reset mid-frame with a frame pending.
        enable      = 1'b1;
        frame_in    = 64'h0123_4567_89AB_CDEF;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        run(75);
        frame_in    = 64'hFFFF_0000_FFFF_0000;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        run(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(30);

        // Randomized traffic with occasional enable drops and resets.
        for (int k = 0; k < 3000; k++) begin
            enable      = ($urandom_range(0, 15) != 0);
            frame_valid = ($urandom_range(0, 3) == 0);
            frame_in    = {$urandom, $urandom};
            rst         = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst         = 1'b0;
        enable      = 1'b0;
        frame_valid = 1'b0;
        run(64 * (DW0 + EXTRA) + 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_scan_ctrl.md
Name: matrix_scan_ctrl

Overview:
- Scan sequencer for the 8x8 row/column decoder. Walks the 6-bit cell address 0..63 with a programmable dwell per cell.
- Holds a double-buffered 64-bit frame: one active buffer being scanned, one pending buffer accepted by handshake.
- Drives the decoder address plus a pixel-enable aligned to the decoder's one-cycle registered output.
- Sits between the frame source (CPU/pattern generator) and the decoder.

Parameters:
- DWELL, default 4: clock cycles each cell address is held; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- frame_in  input  64  new frame. Bit k is cell k; k = {col[2:0], row[2:0]}.
- frame_valid  input  1  frame_in is offered.
- frame_ready  output  1  pending buffer is empty; a frame can be accepted.
- enable  input  1  run scanning.
- add  output  6  cell address to the decoder. add[2:0] is the row, add[5:3] is the column.
- pix_on  output  1  cell state for the decoder outputs currently valid; lags add by 1 cycle.
- frame_done  output  1  one-cycle pulse at the end of each complete 64-cell frame.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values: add=0, pix_on=0, frame_done=0, busy=0, frame_ready=1. Active buffer=0, pending_valid=0, dwell count=0, state=IDLE.
- Handshake:
  - frame_ready = ~pending_valid.
  - On frame_valid && frame_ready at a clock edge: pending <= frame_in, pending_valid <= 1.
  - frame_in is ignored whenever frame_ready=0.
- States are IDLE, SCAN, and BLANK (BLANK exists only with the macro).
- IDLE:
  - If enable=1: go to SCAN with add=0 and count=0. If pending_valid, copy pending to active and clear pending_valid in the same edge.
  - If enable=0: stay in IDLE, hold add at its last value, pix_on=0.
- SCAN:
  - Count increments every cycle. When count==DWELL-1: count<=0 and add<=add+1 (mod 64).
  - Wrap (add==63 and count==DWELL-1):
    - add<=0 and frame_done<=1 for exactly one cycle.
    - If pending_valid: active<=pending and pending_valid<=0, so frame_ready rises on the next cycle.
    - If enable=0: next state is IDLE. Otherwise stay in SCAN.
- enable dropping mid-frame does not stop the scan. The current frame completes and the controller returns to IDLE at the wrap.
- A frame accepted on the wrap edge itself lands in pending only. It is swapped in at the next wrap (swap uses the registered pending_valid).
- Buffers change only at frame boundaries or on IDLE->SCAN. The active buffer is never modified mid-frame.
- pix_on:
  - pix_on <= (state==SCAN) & active[add], registered from the current add.
  - This gives one-cycle alignment with the decoder's registered row/col.
  - pix_on is 0 in the cycle after leaving SCAN.
- DWELL=1: add advances every cycle, and one frame takes 64 cycles.
- Reset mid-frame: all state returns to its reset values on the next edge, including any pending frame being discarded.

Optional Feature:
- Macro SCAN_BLANK_EN.
- Defined:
  - After the last dwell cycle of each cell, SCAN moves to BLANK for exactly 1 cycle. In BLANK, add holds its old value and pix_on is forced to 0 on the next cycle.
  - BLANK then returns to SCAN with add<=add+1 and count=0.
  - Wrap, swap, and frame_done happen on the BLANK->SCAN edge of cell 63.
  - Frame length is 64*(DWELL+1) cycles.
- Undefined: no BLANK state, and frame length is 64*DWELL cycles.

Test Plan:
- Reset, then idle with enable=0 for 10 cycles: add=0, pix_on=0, busy=0, frame_ready=1, frame_done=0 throughout.
- DWELL=2, load frame 64'h1 (cell 0 only), then raise enable:
  - add steps 0,0,1,1,...; pix_on=1 for exactly 2 cycles, starting 1 cycle after add=0.
  - frame_done pulses after 128 cycles; add returns to 0.
- Load A=64'h8000_0000_0000_0001 and start the scan. Offer B=64'hFF mid-frame, then offer C while frame_ready=0:
  - B is accepted; C is not accepted.
  - B is scanned starting from the next frame, and frame_ready=1 the cycle after the swap.
- Deassert enable at add=10 in DWELL=1:
  - Scan continues to add=63, frame_done pulses, state goes to IDLE, busy=0.
  - pix_on=0 from the following cycle.
- Assert rst while add=37 with a pending frame: on the next edge add=0, pix_on=0, frame_ready=1, busy=0. The pending frame is discarded.
- With SCAN_BLANK_EN and DWELL=3: each add value is held 4 cycles, pix_on=0 in each post-blank cycle, and frame_done is 256 cycles apart.
